// File: rtl/y_vector_writer_pkg.sv
// Shared definitions for the y-vector writer: 66-bit float field layout, exception codes, FSM encoding.
`default_nettype none

package y_vector_writer_pkg;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    localparam logic [63:0] IEEE_QNAN = 64'h7FF8_0000_0000_0000;

    localparam int FP66_EXC_MSB  = 65;
    localparam int FP66_EXC_LSB  = 64;
    localparam int FP66_SIGN_BIT = 63;
    localparam int FP66_EXP_MSB  = 62;
    localparam int FP66_EXP_LSB  = 52;
    localparam int FP66_FRAC_MSB = 51;
    localparam int FP66_FRAC_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ywr_state_e;

endpackage

`default_nettype wire

// File: rtl/std_fifo.sv
// Synchronous FIFO with combinational read data and an occupancy count; push while full only with a pop.
`default_nettype none

module std_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 32,
    parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [LOG2_DEPTH:0]   count_o
);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q;
    logic [LOG2_DEPTH-1:0] rd_ptr_q;
    logic [LOG2_DEPTH:0]   count_q;

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (LOG2_DEPTH+1)'(DEPTH));
    assign count_o   = count_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en_i && !rd_en_i)      count_q <= count_q + 1'b1;
            else if (!wr_en_i && rd_en_i) count_q <= count_q - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/y_fp66_to_ieee.sv
// Combinational converter from the 66-bit internal float format to IEEE-754 binary64.
`default_nettype none

module y_fp66_to_ieee
    import y_vector_writer_pkg::*;
(
    input  logic [65:0] fp66_i,
    output logic [63:0] ieee_o
);

    logic w_sign;
    assign w_sign = fp66_i[FP66_SIGN_BIT];

    always_comb begin
        ieee_o = IEEE_QNAN;
        case (fp66_i[FP66_EXC_MSB:FP66_EXC_LSB])
            EXC_ZERO:   ieee_o = {w_sign, 63'b0};
            EXC_NORMAL: ieee_o = {w_sign, fp66_i[FP66_EXP_MSB:FP66_EXP_LSB],
                                  fp66_i[FP66_FRAC_MSB:FP66_FRAC_LSB]};
            EXC_INF:    ieee_o = {w_sign, 11'h7FF, 52'b0};
            default:    ieee_o = IEEE_QNAN;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/y_vector_writer.sv
// SpMV y-output writer: converts row sums to binary64 and stores them to base + 8*row, counting completions.
// Optional build macro YWR_PERF_EN adds stall_cycles / zero_rows performance counters.
`default_nettype none

module y_vector_writer
    import y_vector_writer_pkg::*;
#(
    parameter int FIFO_DEPTH        = 32,
    parameter int LOG2_FIFO_DEPTH   = $clog2(FIFO_DEPTH),
    parameter int ALMOST_FULL_COUNT = 16,
    parameter int ADDR_WIDTH        = 48,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] row_count,
    input  logic                   push_to_y,
    input  logic [65:0]            v_to_y,
    output logic                   y_stall,
    output logic                   mc_req_st,
    output logic [ADDR_WIDTH-1:0]  mc_req_vadr,
    output logic [63:0]            mc_req_wrd,
    input  logic                   mc_wr_rq_stall,
    input  logic                   mc_rsp_push,
`ifdef YWR_PERF_EN
    output logic [31:0]            stall_cycles,
    output logic [31:0]            zero_rows,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam logic [LOG2_FIFO_DEPTH+1:0] C_AF = (LOG2_FIFO_DEPTH+2)'(ALMOST_FULL_COUNT);

    ywr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [COUNT_WIDTH-1:0] rows_q, rows_d;
    logic [COUNT_WIDTH-1:0] accepted_q, accepted_d;
    logic [COUNT_WIDTH-1:0] issued_q, issued_d;
    logic [COUNT_WIDTH-1:0] acked_q, acked_d;
    logic                   error_q, error_d;
    logic                   out_valid_q, out_valid_d;
    logic [63:0]            out_data_q, out_data_d;
    logic                   y_stall_q;

    logic [63:0]                w_ieee;
    logic [63:0]                w_fifo_rd_data;
    logic                       w_fifo_empty;
    logic                       w_fifo_full;
    logic [LOG2_FIFO_DEPTH:0]   w_fifo_count;
    logic [LOG2_FIFO_DEPTH+1:0] w_occ;
    logic                       w_accept;
    logic                       w_load;
    logic                       w_push_ok;
    logic                       w_start_ok;
    logic                       w_rsp_ok;
    logic                       w_err_set;

    y_fp66_to_ieee u_conv (
        .fp66_i (v_to_y),
        .ieee_o (w_ieee)
    );

    std_fifo #(
        .WIDTH      (64),
        .DEPTH      (FIFO_DEPTH),
        .LOG2_DEPTH (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_push_ok),
        .wr_data_i (w_ieee),
        .rd_en_i   (w_load),
        .rd_data_o (w_fifo_rd_data),
        .empty_o   (w_fifo_empty),
        .full_o    (w_fifo_full),
        .count_o   (w_fifo_count)
    );

    // The output register counts as buffer occupancy so the stall threshold sees every held value.
    assign w_occ      = {1'b0, w_fifo_count} + {{(LOG2_FIFO_DEPTH+1){1'b0}}, out_valid_q};
    assign mc_req_st  = out_valid_q && (state_q == ST_RUN);
    assign w_accept   = mc_req_st && !mc_wr_rq_stall;
    assign w_load     = !w_fifo_empty && (!out_valid_q || w_accept);
    assign w_push_ok  = push_to_y && (state_q == ST_RUN) && (accepted_q != rows_q)
                        && (!w_fifo_full || w_load);
    assign w_start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_rsp_ok   = mc_rsp_push && (acked_q != issued_q);
    assign w_err_set  = (push_to_y && !w_push_ok) || (start && !w_start_ok)
                        || (mc_rsp_push && !w_rsp_ok);

    assign mc_req_vadr = base_q + ADDR_WIDTH'({issued_q, 3'b000});
    assign mc_req_wrd  = out_data_q;
    assign y_stall     = y_stall_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        rows_d      = rows_q;
        accepted_d  = accepted_q;
        issued_d    = issued_q;
        acked_d     = acked_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        error_d     = w_err_set || error_q;

        if (w_load) begin
            out_valid_d = 1'b1;
            out_data_d  = w_fifo_rd_data;
        end else if (w_accept) begin
            out_valid_d = 1'b0;
        end
        if (w_push_ok) accepted_d = accepted_q + 1'b1;
        if (w_accept)  issued_d   = issued_q + 1'b1;
        if (w_rsp_ok)  acked_d    = acked_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    base_d     = base_addr;
                    rows_d     = row_count;
                    accepted_d = '0;
                    issued_d   = '0;
                    acked_d    = '0;
                    error_d    = w_err_set;
                    state_d    = (row_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issued_q == rows_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (acked_q == rows_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            rows_q      <= '0;
            accepted_q  <= '0;
            issued_q    <= '0;
            acked_q     <= '0;
            error_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            y_stall_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            rows_q      <= rows_d;
            accepted_q  <= accepted_d;
            issued_q    <= issued_d;
            acked_q     <= acked_d;
            error_q     <= error_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            y_stall_q   <= (w_occ >= C_AF);
        end
    end

`ifdef YWR_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] zero_rows_q;

    assign stall_cycles = stall_cycles_q;
    assign zero_rows    = zero_rows_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            zero_rows_q    <= '0;
        end else if (w_start_ok) begin
            stall_cycles_q <= '0;
            zero_rows_q    <= '0;
        end else begin
            if (mc_req_st && mc_wr_rq_stall && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + 1'b1;
            if (w_push_ok && (v_to_y[FP66_EXC_MSB:FP66_EXC_LSB] == EXC_ZERO)
                && (zero_rows_q != '1))
                zero_rows_q <= zero_rows_q + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_y_vector_writer.sv
// Directed self-checking bench for y_vector_writer with hand-computed expected stores.
`default_nettype none

module tb_y_vector_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [47:0] base_addr;
    logic [31:0] row_count;
    logic        push_to_y;
    logic [65:0] v_to_y;
    logic        y_stall;
    logic        mc_req_st;
    logic [47:0] mc_req_vadr;
    logic [63:0] mc_req_wrd;
    logic        mc_wr_rq_stall;
    logic        mc_rsp_push;
    logic        busy;
    logic        done;
    logic        error;

    logic ack_auto;
    logic ack_manual;
    bit   ack_en;
    assign mc_rsp_push = ack_auto | ack_manual;

    int total = 0;
    int bad   = 0;

    logic [47:0] q_addr[$];
    logic [63:0] q_data[$];
    int stores_seen = 0;
    int acks_sent   = 0;
    int rd_idx      = 0;

    y_vector_writer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .row_count      (row_count),
        .push_to_y      (push_to_y),
        .v_to_y         (v_to_y),
        .y_stall        (y_stall),
        .mc_req_st      (mc_req_st),
        .mc_req_vadr    (mc_req_vadr),
        .mc_req_wrd     (mc_req_wrd),
        .mc_wr_rq_stall (mc_wr_rq_stall),
        .mc_rsp_push    (mc_rsp_push),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mc_req_st && !mc_wr_rq_stall) begin
            q_addr.push_back(mc_req_vadr);
            q_data.push_back(mc_req_wrd);
            stores_seen++;
        end
    end

    always @(negedge clk) begin
        if (ack_en && (acks_sent < stores_seen)) begin
            ack_auto = 1'b1;
            acks_sent++;
        end else begin
            ack_auto = 1'b0;
            if (!ack_en) acks_sent = stores_seen;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [47:0] b, input logic [31:0] n);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        row_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", {63'b0, done}, 64'd1);
    endtask

    task automatic wait_stores(input int n, input int budget);
        int k = 0;
        while (stores_seen < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("store_count", 64'(stores_seen), 64'(n));
    endtask

    task automatic chk_store(input string tag, input logic [47:0] a, input logic [63:0] d);
        if (rd_idx < q_addr.size()) begin
            chk({tag, "_addr"}, {16'b0, q_addr[rd_idx]}, {16'b0, a});
            chk({tag, "_data"}, q_data[rd_idx], d);
        end else begin
            chk({tag, "_missing"}, 64'(q_addr.size()), 64'(rd_idx + 1));
        end
        rd_idx++;
    endtask

    initial begin
        int s0;
        int pushed;
        int k;
        rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0;
        push_to_y = 1'b0; v_to_y = '0; mc_wr_rq_stall = 1'b0;
        ack_manual = 1'b0; ack_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_st", {63'b0, mc_req_st}, 64'd0);
        chk("rst_busy",   {63'b0, busy},      64'd0);
        chk("rst_done",   {63'b0, done},      64'd0);
        chk("rst_error",  {63'b0, error},     64'd0);
        chk("rst_ystall", {63'b0, y_stall},   64'd0);
        rst = 1'b0;
        ack_en = 1'b1;

        // Push while idle: error, nothing stored
        @(negedge clk);
        push_to_y = 1'b1; v_to_y = {2'b01, 64'h1234_0000_0000_0000};
        @(negedge clk);
        push_to_y = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_push_err", {63'b0, error}, 64'd1);
        chk("idle_push_nost", 64'(stores_seen), 64'd0);

        // Single row, latency and completion
        do_start(48'h1000, 32'd1);
        chk("single_busy", {63'b0, busy}, 64'd1);
        chk("start_clr_err", {63'b0, error}, 64'd0);
        push_to_y = 1'b1; v_to_y = {2'b01, 64'h3FF0_0000_0000_0000};
        @(negedge clk);
        push_to_y = 1'b0;
        chk("lat_cycle1", {63'b0, mc_req_st}, 64'd0);
        @(negedge clk);
        chk("lat_cycle2", {63'b0, mc_req_st}, 64'd1);
        chk("single_vadr", {16'b0, mc_req_vadr}, 64'h1000);
        chk("single_wrd", mc_req_wrd, 64'h3FF0_0000_0000_0000);
        wait_done(20);
        chk("single_busy_end", {63'b0, busy}, 64'd0);
        chk("single_err", {63'b0, error}, 64'd0);
        wait_stores(1, 5);
        chk_store("single", 48'h1000, 64'h3FF0_0000_0000_0000);

        // Extra response after everything acknowledged
        @(negedge clk);
        ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0;
        @(negedge clk);
        chk("extra_ack_err", {63'b0, error}, 64'd1);

        // Exception code mapping, sign = 1
        do_start(48'h2000, 32'd4);
        push_to_y = 1'b1; v_to_y = {2'b00, 1'b1, 11'h123, 52'h5};
        @(negedge clk); v_to_y = {2'b01, 64'hC008_0000_0000_0000};
        @(negedge clk); v_to_y = {2'b10, 1'b1, 11'h3FF, 52'h7};
        @(negedge clk); v_to_y = {2'b11, 1'b1, 11'h001, 52'h9};
        @(negedge clk); push_to_y = 1'b0;
        wait_done(30);
        wait_stores(5, 5);
        chk_store("exc_zero", 48'h2000, 64'h8000_0000_0000_0000);
        chk_store("exc_norm", 48'h2008, 64'hC008_0000_0000_0000);
        chk_store("exc_inf",  48'h2010, 64'hFFF0_0000_0000_0000);
        chk_store("exc_nan",  48'h2018, 64'h7FF8_0000_0000_0000);
        chk("exc_err", {63'b0, error}, 64'd0);

        // Back-pressure: 20 pushes under stall, then release
        mc_wr_rq_stall = 1'b1;
        do_start(48'h10000, 32'd40);
        for (int i = 0; i < 20; i++) begin
            if (i == 15) chk("ystall_below", {63'b0, y_stall}, 64'd0);
            if (i == 17) chk("ystall_above", {63'b0, y_stall}, 64'd1);
            push_to_y = 1'b1; v_to_y = {2'b01, 64'h4000_0000_0000_0000 + 64'(i)};
            @(negedge clk);
        end
        push_to_y = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_err", {63'b0, error}, 64'd0);
        chk("bp_hold_st", {63'b0, mc_req_st}, 64'd1);
        chk("bp_hold_adr", {16'b0, mc_req_vadr}, 64'h10000);
        chk("bp_hold_wrd", mc_req_wrd, 64'h4000_0000_0000_0000);
        mc_wr_rq_stall = 1'b0;
        pushed = 20; k = 0;
        while (pushed < 40 && k < 200) begin
            if (!y_stall) begin
                push_to_y = 1'b1; v_to_y = {2'b01, 64'h4000_0000_0000_0000 + 64'(pushed)};
                pushed++;
            end else begin
                push_to_y = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        push_to_y = 1'b0;
        wait_done(200);
        wait_stores(45, 5);
        for (int i = 0; i < 40; i++)
            chk_store("bp", 48'h10000 + 48'(8 * i), 64'h4000_0000_0000_0000 + 64'(i));
        chk("bp_err_end", {63'b0, error}, 64'd0);

        // Reset mid-run after 5 of 10 stores
        do_start(48'h3000, 32'd10);
        s0 = stores_seen; k = 0;
        while (stores_seen - s0 < 5 && k < 40) begin
            push_to_y = (k < 10);
            v_to_y = {2'b01, 64'h5000_0000_0000_0000 + 64'(k)};
            @(negedge clk);
            k++;
        end
        chk("mid_issued5", 64'(stores_seen - s0), 64'd5);
        push_to_y = 1'b0;
        ack_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_st",   {63'b0, mc_req_st}, 64'd0);
        chk("mid_rst_busy", {63'b0, busy},      64'd0);
        chk("mid_rst_done", {63'b0, done},      64'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_idx = q_addr.size();
        ack_en = 1'b1;
        do_start(48'h5000, 32'd2);
        push_to_y = 1'b1; v_to_y = {2'b01, 64'h3FF8_0000_0000_0000};
        @(negedge clk); v_to_y = {2'b10, 1'b0, 63'h0};
        @(negedge clk); push_to_y = 1'b0;
        wait_done(30);
        s0 = rd_idx;
        wait_stores(s0 + 2, 5);
        chk_store("post_rst0", 48'h5000, 64'h3FF8_0000_0000_0000);
        chk_store("post_rst1", 48'h5008, 64'h7FF0_0000_0000_0000);
        chk("post_rst_err", {63'b0, error}, 64'd0);

        // Zero rows
        s0 = stores_seen;
        do_start(48'h7000, 32'd0);
        chk("zero_done", {63'b0, done}, 64'd1);
        chk("zero_busy", {63'b0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("zero_nost", 64'(stores_seen), 64'(s0));
        chk("zero_err", {63'b0, error}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
